// File: rtl/gpu_pkg.sv
// Shared opcodes, instruction field positions and sequencer states for the gpu shader core.
package gpu_pkg;

    localparam int PROG_DEPTH = 1024;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_SHL  = 4'h7;
    localparam logic [3:0] OP_SHR  = 4'h8;
    localparam logic [3:0] OP_ADDI = 4'h9;
    localparam logic [3:0] OP_PIX  = 4'hA;
    localparam logic [3:0] OP_BNZ  = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_SEND = 4'hD;
    localparam logic [3:0] OP_RSVD = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam int OP_LSB = 12;
    localparam int RD_LSB = 9;
    localparam int RS_LSB = 6;
    localparam int RT_LSB = 3;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_RUN,
        ST_HALT
    } state_t;

endpackage

// File: rtl/gpu_alu.sv
// Combinational datapath for the register-writing opcodes (LDI through ADDI).
// Zero latency; no flow control.
module gpu_alu
    import gpu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [8:0]  imm,
    output logic [15:0] result
);

    always_comb begin
        result = '0;
        case (op)
            OP_LDI:  result = {7'd0, imm};
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SHL:  result = a << b[3:0];
            OP_SHR:  result = a >> b[3:0];
            OP_ADDI: result = a + {{10{imm[5]}}, imm[5:0]};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/gpu.sv
// In-order shader core: captures a parallel program image, then retires one instruction per clock.
// Pixel/frame strobes are registered one cycle after PIX/SEND; no backpressure from the framebuffer.
module gpu
    import gpu_pkg::*;
#(
    parameter int DATA_DEPTH = PROG_DEPTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        prog_loading,
    input  logic [DATA_DEPTH-1:0][15:0] data_frames_in,
    output logic                        pix_we,
    output logic [15:0]                 pix_addr,
    output logic [15:0]                 pix_data,
    output logic                        frame_being_sent,
    output logic                        halted
);

    localparam int PC_W = $clog2(DATA_DEPTH);

    logic [DATA_DEPTH-1:0][15:0] mem;
    logic [15:0]                 regs [8];
    logic [PC_W-1:0]             pc;
    logic [PC_W-1:0]             pc_next;
    state_t                      state;

    logic [15:0] instr;
    logic [3:0]  op;
    logic [2:0]  rd, rs, rt;
    logic [15:0] alu_res;
    logic        wb_en;

    assign instr = mem[pc];
    assign op    = instr[OP_LSB +: 4];
    assign rd    = instr[RD_LSB +: 3];
    assign rs    = instr[RS_LSB +: 3];
    assign rt    = instr[RT_LSB +: 3];
    assign wb_en = (op >= OP_LDI) && (op <= OP_ADDI);

    gpu_alu u_alu (
        .op     (op),
        .a      (regs[rs]),
        .b      (regs[rt]),
        .imm    (instr[8:0]),
        .result (alu_res)
    );

    // Program memory is deliberately outside the reset domain so a reset reruns the retained image.
    always_ff @(posedge clk) begin
        if (prog_loading) begin
            mem <= data_frames_in;
        end
    end

    always_comb begin
        pc_next = pc + PC_W'(1);
        case (op)
            OP_BNZ:  if (regs[rd] != 16'd0) pc_next = pc + PC_W'($signed(instr[8:0]));
            OP_JMP:  pc_next = instr[PC_W-1:0];
            OP_HALT: pc_next = pc;
            default: pc_next = pc + PC_W'(1);
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= ST_RUN;
            pc               <= '0;
            halted           <= 1'b0;
            pix_we           <= 1'b0;
            pix_addr         <= '0;
            pix_data         <= '0;
            frame_being_sent <= 1'b0;
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else if (prog_loading) begin
            state            <= ST_LOAD;
            pc               <= '0;
            halted           <= 1'b0;
            pix_we           <= 1'b0;
            frame_being_sent <= 1'b0;
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else begin
            pix_we           <= 1'b0;
            frame_being_sent <= 1'b0;
            // LOAD falls straight into execution: mem[0] retires on the first non-loading clock.
            if (state != ST_HALT) begin
                state  <= (op == OP_HALT) ? ST_HALT : ST_RUN;
                halted <= (op == OP_HALT);
                pc     <= pc_next;
                if (wb_en) regs[rd] <= alu_res;
                if (op == OP_PIX) begin
                    pix_we   <= 1'b1;
                    pix_addr <= regs[rd];
                    pix_data <= regs[rs];
                end
                if (op == OP_SEND) frame_being_sent <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gpu.sv
// Randomised and directed checking of gpu against an instruction-level interpreter.
module tb_gpu;
    import gpu_pkg::*;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  prog_loading;
    logic [1023:0][15:0]   image;
    logic                  pix_we;
    logic [15:0]           pix_addr;
    logic [15:0]           pix_data;
    logic                  frame_being_sent;
    logic                  halted;

    gpu #(.DATA_DEPTH(1024)) dut (
        .clk              (clk),
        .reset            (reset),
        .prog_loading     (prog_loading),
        .data_frames_in   (image),
        .pix_we           (pix_we),
        .pix_addr         (pix_addr),
        .pix_data         (pix_data),
        .frame_being_sent (frame_being_sent),
        .halted           (halted)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Interpreter state
    logic [15:0] m_mem [1024];
    logic [15:0] m_regs [8];
    int          m_pc;
    logic        m_halted;
    logic        e_we, e_fbs;
    logic [15:0] e_addr, e_data;

    logic [31:0] pix_q [$];
    int          send_cnt;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_halted = 1'b0;
        e_we = 1'b0; e_fbs = 1'b0; e_addr = '0; e_data = '0;
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
    endtask

    task automatic model_clock();
        logic [15:0] w;
        int op, rd, rs, rt, npc;
        e_we = 1'b0; e_fbs = 1'b0;
        if (prog_loading) begin
            for (int i = 0; i < 1024; i++) m_mem[i] = image[i];
            m_pc = 0; m_halted = 1'b0;
            for (int i = 0; i < 8; i++) m_regs[i] = '0;
            return;
        end
        if (m_halted) return;
        w  = m_mem[m_pc];
        op = int'(w[15:12]); rd = int'(w[11:9]); rs = int'(w[8:6]); rt = int'(w[5:3]);
        npc = (m_pc + 1) % 1024;
        case (op)
            1:  m_regs[rd] = 16'(w[8:0]);
            2:  m_regs[rd] = m_regs[rs] + m_regs[rt];
            3:  m_regs[rd] = m_regs[rs] - m_regs[rt];
            4:  m_regs[rd] = m_regs[rs] & m_regs[rt];
            5:  m_regs[rd] = m_regs[rs] | m_regs[rt];
            6:  m_regs[rd] = m_regs[rs] ^ m_regs[rt];
            7:  m_regs[rd] = m_regs[rs] << m_regs[rt][3:0];
            8:  m_regs[rd] = m_regs[rs] >> m_regs[rt][3:0];
            9:  m_regs[rd] = m_regs[rs] + 16'(int'($signed(w[5:0])));
            10: begin e_we = 1'b1; e_addr = m_regs[rd]; e_data = m_regs[rs]; end
            11: if (m_regs[rd] != 16'd0) npc = (m_pc + int'($signed(w[8:0])) + 1024) % 1024;
            12: npc = int'(w[9:0]);
            13: e_fbs = 1'b1;
            15: begin m_halted = 1'b1; npc = m_pc; end
            default: ;
        endcase
        m_pc = npc;
    endtask

    task automatic compare_outputs();
        check("pix_we", 32'(pix_we), 32'(e_we));
        check("pix_addr", 32'(pix_addr), 32'(e_addr));
        check("pix_data", 32'(pix_data), 32'(e_data));
        check("frame", 32'(frame_being_sent), 32'(e_fbs));
        check("halted", 32'(halted), 32'(m_halted));
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_clock();
        #1;
        compare_outputs();
        if (pix_we) pix_q.push_back({pix_addr, pix_data});
        if (frame_being_sent) send_cnt++;
    endtask

    task automatic run_prog(input int cycles);
        prog_loading = 1'b1;
        tick(); tick();
        prog_loading = 1'b0;
        pix_q.delete(); send_cnt = 0;
        repeat (cycles) tick();
    endtask

    function automatic logic [15:0] e_r(input logic [3:0] op, input int d, input int s, input int t);
        return {op, 3'(d), 3'(s), 3'(t), 3'b000};
    endfunction
    function automatic logic [15:0] e_i9(input logic [3:0] op, input int d, input int imm);
        return {op, 3'(d), 9'(imm)};
    endfunction
    function automatic logic [15:0] e_i6(input logic [3:0] op, input int d, input int s, input int imm);
        return {op, 3'(d), 3'(s), 6'(imm)};
    endfunction

    task automatic set_loop_prog();
        image = '0;
        image[0] = e_i9(OP_LDI, 1, 1);
        image[1] = e_r(OP_ADD, 2, 2, 1);
        image[2] = e_r(OP_PIX, 2, 2, 0);
        image[3] = {OP_JMP, 12'd1};
    endtask

    initial begin
        logic [15:0] w;
        reset = 1'b0; prog_loading = 1'b0; image = '0;
        model_reset();
        #12;
        compare_outputs();
        tick();
        reset = 1'b1;

        // Basic: one pixel then halt
        image = '0;
        image[0] = e_i9(OP_LDI, 1, 5);
        image[1] = e_i9(OP_LDI, 2, 7);
        image[2] = e_r(OP_ADD, 3, 1, 2);
        image[3] = e_r(OP_PIX, 3, 1, 0);
        image[4] = {OP_HALT, 12'd0};
        run_prog(12);
        check("basic_writes", pix_q.size(), 1);
        if (pix_q.size() > 0) check("basic_pix", pix_q[0], {16'd12, 16'd5});
        check("basic_halted", 32'(halted), 1);

        // Countdown loop with frame strobe
        image = '0;
        image[0] = e_i9(OP_LDI, 1, 3);
        image[1] = e_r(OP_PIX, 1, 1, 0);
        image[2] = e_i6(OP_ADDI, 1, 1, -1);
        image[3] = e_i9(OP_BNZ, 1, -2);
        image[4] = {OP_SEND, 12'd0};
        image[5] = {OP_HALT, 12'd0};
        run_prog(20);
        check("loop_writes", pix_q.size(), 3);
        for (int i = 0; i < 3 && i < pix_q.size(); i++)
            check("loop_pix", pix_q[i], {16'(3 - i), 16'(3 - i)});
        check("loop_sends", send_cnt, 1);

        // Arithmetic edges
        image = '0;
        image[0]  = e_i9(OP_LDI, 1, 0);
        image[1]  = e_i9(OP_LDI, 2, 1);
        image[2]  = e_r(OP_SUB, 3, 1, 2);
        image[3]  = e_r(OP_PIX, 3, 3, 0);
        image[4]  = e_i9(OP_LDI, 4, 15);
        image[5]  = e_r(OP_SHL, 5, 2, 4);
        image[6]  = e_r(OP_PIX, 5, 5, 0);
        image[7]  = e_r(OP_SHR, 6, 5, 4);
        image[8]  = e_r(OP_PIX, 6, 6, 0);
        image[9]  = e_i6(OP_ADDI, 7, 3, 1);
        image[10] = e_r(OP_PIX, 7, 3, 0);
        image[11] = {OP_HALT, 12'd0};
        run_prog(16);
        check("arith_writes", pix_q.size(), 4);
        if (pix_q.size() == 4) begin
            check("sub_wrap", pix_q[0], 32'hFFFF_FFFF);
            check("shl15", pix_q[1], 32'h8000_8000);
            check("shr15", pix_q[2], 32'h0001_0001);
            check("addi_wrap", pix_q[3], 32'h0000_FFFF);
        end

        // PC wrap from 1023 to 0
        image = '0;
        image[0]    = e_i9(OP_BNZ, 1, 3);
        image[1]    = e_i9(OP_LDI, 1, 9);
        image[2]    = {OP_JMP, 12'd1023};
        image[3]    = {OP_SEND, 12'd0};
        image[4]    = {OP_HALT, 12'd0};
        image[1023] = e_r(OP_PIX, 1, 1, 0);
        run_prog(12);
        check("wrap_writes", pix_q.size(), 1);
        if (pix_q.size() > 0) check("wrap_pix", pix_q[0], {16'd9, 16'd9});
        check("wrap_sends", send_cnt, 1);

        // Reload mid-run: registers must come back cleared
        set_loop_prog();
        run_prog(10);
        image = '0;
        image[0] = e_r(OP_PIX, 2, 2, 0);
        image[1] = {OP_SEND, 12'd0};
        image[2] = {OP_HALT, 12'd0};
        run_prog(6);
        check("reload_writes", pix_q.size(), 1);
        if (pix_q.size() > 0) check("reload_pix", pix_q[0], 0);
        check("reload_sends", send_cnt, 1);

        // Async reset mid pixel stream, then rerun retained program
        set_loop_prog();
        run_prog(9);
        #2 reset = 1'b0;
        #1;
        model_reset();
        check("async_we", 32'(pix_we), 0);
        check("async_addr", 32'(pix_addr), 0);
        check("async_data", 32'(pix_data), 0);
        check("async_frame", 32'(frame_being_sent), 0);
        check("async_halted", 32'(halted), 0);
        tick(); tick();
        reset = 1'b1;
        pix_q.delete(); send_cnt = 0;
        repeat (8) tick();
        check("rst_restart_writes", pix_q.size(), 2);
        if (pix_q.size() > 0) check("rst_restart_pix", pix_q[0], {16'd1, 16'd1});

        // Random programs with occasional mid-run reload
        for (int p = 0; p < 20; p++) begin
            image = '0;
            for (int j = 0; j < 48; j++) begin
                w = 16'($urandom);
                if (w[15:12] == OP_HALT && $urandom_range(0, 3) != 0) w[15:12] = OP_ADD;
                image[j] = w;
            end
            if ($urandom_range(0, 3) == 0) image[1023] = e_r(OP_PIX, 1, 2, 0);
            run_prog(150);
            if ($urandom_range(0, 2) == 0) begin
                prog_loading = 1'b1;
                tick();
                prog_loading = 1'b0;
                repeat (40) tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gpu.md
# gpu

Minimal in-order shader processor. A 1024×16-bit program image is presented in parallel and captured while `prog_loading` is high. After loading, the block executes one 16-bit instruction per clock on an 8×16-bit register file. Pixel writes go out on a registered framebuffer write port, and a frame-done strobe is raised. It sits between the host/program loader and the framebuffer.

## Interface
- `DATA_DEPTH`, default 1024: program words; PC is `$clog2(DATA_DEPTH)` bits.
- `clk` input, 1 bit: single clock; all state is on the rising edge.
- `reset` input, 1 bit: asynchronous, active-low. This polarity and synchronicity are fixed.
- `prog_loading` input, 1 bit: 1 = capture program and hold execution; 0 = run.
- `data_frames_in` input, `[DATA_DEPTH-1:0][15:0]`: parallel program image; word j is the instruction at address j.
- `pix_we` output, 1 bit: one-cycle framebuffer write strobe.
- `pix_addr` output, 16 bits: framebuffer address.
- `pix_data` output, 16 bits: pixel value.
- `frame_being_sent` output, 1 bit: one-cycle strobe marking frame completion.
- `halted` output, 1 bit: high after HALT until reset or reload.

## Operation
- Instruction fields: `op=[15:12]`, `rd=[11:9]`, `rs=[8:6]`, `rt=[5:3]`, `imm9=[8:0]`, `imm6=[5:0]`, `imm12=[11:0]`.
- Opcodes:
  - 0 NOP.
  - 1 LDI: `rd=zext(imm9)`.
  - 2 ADD: `rd=rs+rt`.
  - 3 SUB: `rd=rs-rt`.
  - 4 AND.
  - 5 OR.
  - 6 XOR.
  - 7 SHL: `rd=rs<<rt[3:0]`.
  - 8 SHR (logical): `rd=rs>>rt[3:0]`.
  - 9 ADDI: `rd=rs+sext(imm6)`.
  - A PIX: `pix_addr=R[rd]`, `pix_data=R[rs]`, `pix_we=1`.
  - B BNZ: if `R[rd]!=0` then `pc=pc+sext(imm9)`, else `pc+1`.
  - C JMP: `pc=imm12[9:0]`.
  - D SEND: `frame_being_sent=1`.
  - E is reserved and behaves as NOP.
  - F HALT.
- Arithmetic is 16-bit modulo 2^16. There are no flags. All 8 registers are general purpose; R0 is not hardwired.
- The PC is 10-bit and wraps from 1023 to 0. Branch targets also wrap modulo 1024.
- Load mode (`prog_loading=1`):
  - Every clock, `mem[j] <= data_frames_in[j]` for all j.
  - `pc=0`, registers cleared, `halted=0`, strobes 0.
  - No instruction executes.
- Run mode: on the first clock with `prog_loading=0`, `mem[0]` executes. One instruction retires per clock.
- Halted state: pc frozen, no writes or strobes. Only reset or reload exits it.
- Raising `prog_loading` mid-run aborts execution immediately. The block reloads and restarts from 0 when `prog_loading` drops.
- Reset (`reset=0`):
  - pc, registers, `halted`, `pix_*`, and `frame_being_sent` go to 0 asynchronously.
  - Program memory contents are not cleared.
  - After reset release with `prog_loading=0`, execution restarts at address 0 using the retained memory.

## Timing
- States: LOAD, RUN, HALT.
  - Any state → LOAD on `prog_loading=1`.
  - LOAD → RUN when `prog_loading=0`.
  - RUN → HALT on op F.
- Register writeback: a value written in cycle n is readable by the instruction in cycle n+1. There are no hazards.
- `pix_we`, `pix_addr`, `pix_data`, and `frame_being_sent` are registered. They assert in the cycle after PIX/SEND executes and last exactly one cycle. `pix_addr`/`pix_data` hold their last value when `pix_we=0`.
- `halted` rises in the cycle after HALT executes.
- Reset values of all outputs are 0.

## Structure
- Shared package `gpu_pkg`:
  - opcode localparams (`OP_NOP`…`OP_HALT`).
  - field position constants.
  - state enum.
  - `PROG_DEPTH=1024`.
- One natural sub-module, `gpu_alu`: combinational, takes op, a, b, imm and produces the 16-bit result.
- Program memory, register file, PC, and sequencer live in `gpu`.

## Test plan
- Reset then load `{LDI r1,5; LDI r2,7; ADD r3,r1,r2; PIX r3,r1; HALT}` → one `pix_we` pulse with `addr=12`, `data=5`; then `halted=1` and no further strobes.
- Loop: `LDI r1,3; PIX r1,r1; ADDI r1,r1,-1; BNZ r1,-2; SEND; HALT` → exactly 3 writes with `addr/data` 3, 2, 1; then one `frame_being_sent` pulse; then halt.
- Arithmetic edges: `SUB` of 0-1 gives 0xFFFF; `SHL` of 1 by 15 gives 0x8000; `SHR` of 0x8000 by 15 gives 1; `ADDI` of 0xFFFF+1 gives 0.
- Wrap: `JMP 1023` where word 1023 is PIX and words 0.. hold the program → the PIX at 1023 executes, and execution continues at 0.
- Raise `prog_loading` mid-run, change the image, drop it → the new program runs from 0 with registers cleared.
- Assert reset mid-PIX-stream → outputs go to 0 asynchronously; after release the retained program restarts at 0.
